// File: rtl/gf233_pkg.sv
// Shared constants for the GF(2^233) Itoh-Tsujii inversion sequencer:
// field parameters, controller states and the fixed addition chain.
package gf233_pkg;

    // Field width and middle tap of the trinomial x^233 + x^74 + 1
    localparam int W     = 233;
    localparam int TAP   = 74;

    // Addition-chain length and register widths for the step/squaring counters
    localparam int NSTEP  = 10;
    localparam int STEP_W = 4;
    localparam int CNT_W  = 7;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Squarings performed in each step before the multiplication.
    // Chain: beta_1 -> 2, 3, 6, 7, 14, 28, 29, 58, 116, 232.
    localparam logic [CNT_W-1:0] CHAIN_J [0:NSTEP-1] = '{
        7'd1, 7'd1, 7'd3, 7'd1, 7'd7, 7'd14, 7'd1, 7'd29, 7'd58, 7'd116
    };

    // Second multiplier operand per step: 1 = input copy A, 0 = saved S
    localparam logic CHAIN_SEL_A [0:NSTEP-1] = '{
        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0
    };

endpackage

// File: rtl/gf233_itoh_tsujii_inv_sqr.sv
// Combinational single-step squarer in GF(2^233), modulus x^233 + x^74 + 1.
// Squaring spreads bit i to position 2i; positions >= 233 are folded back
// with x^233 = x^74 + 1, which needs a second fold for the highest bits.
module gf233_itoh_tsujii_inv_sqr
    import gf233_pkg::*;
(
    input  logic [W-1:0] a_in,
    output logic [W-1:0] sq_out
);

    // Closed-form reduction of the spread polynomial, accumulated bitwise
    always_comb begin
        sq_out = '0;
        for (int i = 0; i < W; i++) begin
            if (2 * i < W) begin
                // x^(2i) already reduced
                sq_out[2*i] = sq_out[2*i] ^ a_in[i];
            end else begin
                // x^(2i) = x^(2i-233) + x^(2i-159)
                sq_out[2*i-W] = sq_out[2*i-W] ^ a_in[i];
                if (2 * i - W + TAP < W) begin
                    sq_out[2*i-W+TAP] = sq_out[2*i-W+TAP] ^ a_in[i];
                end else begin
                    // x^(2i-159) folds once more: x^(2i-392) + x^(2i-318)
                    sq_out[2*i-2*W+TAP]   = sq_out[2*i-2*W+TAP] ^ a_in[i];
                    sq_out[2*i-2*W+2*TAP] = sq_out[2*i-2*W+2*TAP] ^ a_in[i];
                end
            end
        end
    end

endmodule

// File: rtl/gf233_itoh_tsujii_inv.sv
// Itoh-Tsujii inversion sequencer for GF(2^233): a^-1 = a^(2^233 - 2).
// Walks a fixed 10-step addition chain, squaring one bit-step per clock
// with a local squarer and borrowing the shared multiplier via req/ack.
module gf233_itoh_tsujii_inv
    import gf233_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [W-1:0] DIN,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] DOUT,
    output logic         ZERO_IN,
    output logic         MUL_REQ,
    output logic [W-1:0] MUL_A,
    output logic [W-1:0] MUL_B,
    input  logic         MUL_ACK,
    input  logic [W-1:0] MUL_P
);

    state_t              state_q, state_d;
    logic [W-1:0]        a_q, a_d;        // input copy
    logic [W-1:0]        t_q, t_d;        // working value beta_k
    logic [W-1:0]        s_q, s_d;        // beta value saved at step entry
    logic [STEP_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]        dout_q, dout_d;
    logic                zero_q, zero_d;
    logic                done_q, done_d;

    logic [W-1:0]        sq_t;
    logic [STEP_W-1:0]   step_inc;
    logic                in_mul;
    logic                sel_a;

    gf233_itoh_tsujii_inv_sqr u_sqr (
        .a_in   (t_q),
        .sq_out (sq_t)
    );

    assign step_inc = step_q + 4'd1;
    assign in_mul   = (state_q == MUL);
    assign sel_a    = CHAIN_SEL_A[step_q];

    // Multiplier operands come straight from registers that are frozen in MUL
    assign MUL_REQ = in_mul;
    assign MUL_A   = in_mul ? t_q : '0;
    assign MUL_B   = in_mul ? (sel_a ? a_q : s_q) : '0;

    assign BUSY    = (state_q != IDLE);
    assign DONE    = done_q;
    assign DOUT    = dout_q;
    assign ZERO_IN = zero_q;

    // Next-state and datapath updates for the chain walk
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        t_d     = t_q;
        s_d     = s_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d     = DIN;
                    t_d     = DIN;
                    s_d     = DIN;
                    step_d  = '0;
                    cnt_d   = CHAIN_J[0];
                    state_d = SQR;
                end
            end

            SQR: begin
                t_d   = sq_t;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    state_d = MUL;
                end
            end

            MUL: begin
                if (MUL_ACK) begin
                    t_d = MUL_P;
                    if (step_q == STEP_W'(NSTEP - 1)) begin
                        state_d = FIN;
                    end else begin
                        // Next step starts from the fresh product
                        step_d  = step_inc;
                        s_d     = MUL_P;
                        cnt_d   = CHAIN_J[step_inc];
                        state_d = SQR;
                    end
                end
            end

            FIN: begin
                // Last squaring turns beta_232 into a^(2^233 - 2)
                dout_d  = sq_t;
                zero_d  = (a_q == '0);
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            t_q     <= '0;
            s_q     <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            t_q     <= t_d;
            s_q     <= s_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_gf233_itoh_tsujii_inv.sv
// Bench for the GF(2^233) inversion sequencer: field-level model of the
// inverse and expected latency, a delayed-ack multiplier responder, and a
// single negedge compare process.
module tb_gf233_itoh_tsujii_inv;

    localparam int W = 233;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [W-1:0] DIN;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] DOUT;
    logic         ZERO_IN;
    logic         MUL_REQ;
    logic [W-1:0] MUL_A;
    logic [W-1:0] MUL_B;
    logic         MUL_ACK;
    logic [W-1:0] MUL_P;

    gf233_itoh_tsujii_inv dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .DIN     (DIN),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .DOUT    (DOUT),
        .ZERO_IN (ZERO_IN),
        .MUL_REQ (MUL_REQ),
        .MUL_A   (MUL_A),
        .MUL_B   (MUL_B),
        .MUL_ACK (MUL_ACK),
        .MUL_P   (MUL_P)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] expv;
        bit           expz;
        int           start;
        int           base;
    } op_t;

    op_t          q[$];
    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    int           delay_total = 0;
    int           max_delay   = 0;
    bit           rst_edge    = 1'b0;
    logic [W-1:0] last_dout   = '0;

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        rst_edge <= RST;
    end

    // ---------------- field model ----------------
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [W-1:0] x;
        logic         c;
        r = '0;
        x = a;
        for (int i = 0; i < W; i++) begin
            if (b[i]) r = r ^ x;
            c = x[W-1];
            x = x << 1;
            if (c) begin
                x[0]  = ~x[0];
                x[74] = ~x[74];
            end
        end
        return r;
    endfunction

    // a^(2^233-2) = product of a^(2^i) for i = 1..232
    function automatic logic [W-1:0] gf_inv(input logic [W-1:0] a);
        logic [W-1:0] p;
        logic [W-1:0] r;
        p = a;
        r = 233'd1;
        for (int i = 1; i < W; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd233();
        logic [255:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        if (t[W-1:0] == '0) t[0] = 1'b1;
        return t[W-1:0];
    endfunction

    function automatic void chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // ---------------- multiplier responder ----------------
    initial begin
        bit active;
        int cur_d;
        int waited;
        active  = 1'b0;
        cur_d   = 0;
        waited  = 0;
        MUL_ACK = 1'b0;
        MUL_P   = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (RST) begin
                active  = 1'b0;
                MUL_ACK = 1'b0;
            end else if (MUL_REQ) begin
                if (!active) begin
                    active      = 1'b1;
                    cur_d       = $urandom_range(0, max_delay);
                    delay_total = delay_total + cur_d;
                    waited      = 0;
                end
                if (waited == cur_d) begin
                    MUL_ACK = 1'b1;
                    MUL_P   = gf_mul(MUL_A, MUL_B);
                    active  = 1'b0;
                end else begin
                    waited++;
                    MUL_ACK = 1'b0;
                end
            end else begin
                MUL_ACK = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        bit           hold_req;
        logic [W-1:0] hold_a;
        logic [W-1:0] hold_b;
        bit           exp_busy;
        bit           exp_done;
        int           el;
        int           lat;
        hold_req = 1'b0;
        hold_a   = '0;
        hold_b   = '0;
        forever begin
            @(negedge CLK);
            if (rst_edge) begin
                chk("rst_busy",    BUSY,    '0);
                chk("rst_done",    DONE,    '0);
                chk("rst_zero_in", ZERO_IN, '0);
                chk("rst_mul_req", MUL_REQ, '0);
                chk("rst_mul_a",   MUL_A,   '0);
                chk("rst_mul_b",   MUL_B,   '0);
                chk("rst_dout",    DOUT,    '0);
                hold_req = 1'b0;
            end else if (!RST) begin
                exp_busy = 1'b0;
                exp_done = 1'b0;
                if (q.size() > 0 && cyc >= q[0].start) begin
                    el       = cyc - q[0].start;
                    lat      = 242 + delay_total - q[0].base;
                    exp_busy = (el < lat);
                    exp_done = (el == lat);
                end
                chk("busy", BUSY, exp_busy);
                chk("done", DONE, exp_done);
                if (exp_done) begin
                    chk("dout", DOUT, q[0].expv);
                    chk("zero_in", ZERO_IN, q[0].expz);
                    if (q[0].din != '0) chk("din_x_dout", gf_mul(q[0].din, DOUT), 233'd1);
                    last_dout = q[0].expv;
                    void'(q.pop_front());
                end else begin
                    chk("dout_hold", DOUT, last_dout);
                end
                if (MUL_REQ && hold_req) begin
                    chk("mul_a_stable", MUL_A, hold_a);
                    chk("mul_b_stable", MUL_B, hold_b);
                end
                hold_req = MUL_REQ && !MUL_ACK;
                hold_a   = MUL_A;
                hold_b   = MUL_B;
            end else begin
                hold_req = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; START is sampled by the following edge
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] expv);
        op_t o;
        o.din   = a;
        o.expv  = expv;
        o.expz  = (a == '0);
        o.start = cyc + 1;
        o.base  = delay_total;
        q.push_back(o);
        DIN   = a;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        q.delete();
        last_dout = '0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: %0d results still pending after %0d cycles, required 0", q.size(), budget);
            pulse_reset();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] lit2;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           n;

        RST   = 1'b1;
        START = 1'b0;
        DIN   = '0;

        // Hand-derived results pin the model: x^-1 = x^232 + x^73
        lit2      = '0;
        lit2[232] = 1'b1;
        lit2[73]  = 1'b1;
        chk("model_inv_x",   gf_inv(233'd2), lit2);
        chk("model_x_lit",   gf_mul(233'd2, lit2), 233'd1);
        chk("model_inv_one", gf_inv(233'd1), 233'd1);
        chk("model_inv_zero", gf_inv(233'd0), 233'd0);

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Directed operands with immediate ack: exactly 242 edges
        max_delay = 0;
        start_op(233'd1, 233'd1);
        wait_idle(400);
        start_op(233'd2, lit2);
        wait_idle(400);
        start_op(233'd0, 233'd0);
        wait_idle(400);

        // Random operands with ack delays 0..5
        max_delay = 5;
        for (int k = 0; k < 4; k++) begin
            a = rnd233();
            start_op(a, gf_inv(a));
            wait_idle(1000);
        end

        // A second START mid-run must be dropped
        a = rnd233();
        start_op(a, gf_inv(a));
        repeat (49) begin
            @(posedge CLK);
            #1;
        end
        DIN   = rnd233();
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_idle(1000);

        // START in the DONE cycle is accepted
        a = rnd233();
        b = rnd233();
        start_op(a, gf_inv(a));
        n = 0;
        while (!DONE && n < 1000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!DONE) begin
            vectors++;
            miscompares++;
            $display("FAIL done_wait: DONE=%0b after %0d cycles, required 1", DONE, n);
            pulse_reset();
        end else begin
            start_op(b, gf_inv(b));
        end
        wait_idle(1000);

        // Reset around cycle 100 while a multiplication is outstanding
        max_delay = 3;
        a = rnd233();
        start_op(a, gf_inv(a));
        repeat (99) begin
            @(posedge CLK);
            #1;
        end
        n = 0;
        while (!MUL_REQ && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!MUL_REQ) begin
            vectors++;
            miscompares++;
            $display("FAIL mul_req_wait: MUL_REQ=%0b, required 1", MUL_REQ);
        end
        pulse_reset();
        @(posedge CLK);
        #1;
        b = rnd233();
        start_op(b, gf_inv(b));
        wait_idle(1000);

        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
